// File: rtl/opa_decode_stage.sv
// opa_decode_stage: RV32I operand-A select decode, registered behind a 2-entry skid FIFO.
// Revision: 1.0 - initial release
`default_nettype none

module opa_decode_stage #(
   parameter int XLEN   = 32,
   parameter int ZIMM_W = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            io_in_valid,
   output logic            io_in_ready,
   input  logic [31:0]     io_in_inst,
   input  logic [XLEN-1:0] io_in_rs1_data,
   input  logic            io_flush,
   output logic            io_out_valid,
   input  logic            io_out_ready,
   output logic [1:0]      io_opa_sel,
   output logic [XLEN-1:0] io_opa_rsa,
   output logic [XLEN-1:0] io_opa_imz,
   output logic [XLEN-1:0] io_opa_imu,
   output logic            io_out_illegal
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_MISC   = 7'b0001111;

   localparam logic [1:0] SEL_RSA = 2'd0;
   localparam logic [1:0] SEL_IMU = 2'd1;
   localparam logic [1:0] SEL_IMZ = 2'd2;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [1:0]      dec_sel;
   logic            dec_illegal;
   logic [XLEN-1:0] dec_imz;
   logic [XLEN-1:0] dec_imu;
   logic            unused_inst_bits;

   assign opcode           = io_in_inst[6:0];
   assign funct3           = io_in_inst[14:12];
   assign unused_inst_bits = ^io_in_inst[11:7];

   always_comb begin
      dec_sel     = SEL_RSA;
      dec_illegal = 1'b0;
      case (opcode)
         OPC_LUI, OPC_AUIPC: dec_sel = SEL_IMU;
         OPC_SYSTEM:         if (funct3 >= 3'd5) dec_sel = SEL_IMZ;
         OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE,
         OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_MISC: dec_sel = SEL_RSA;
         default:            dec_illegal = 1'b1;
      endcase
   end

   always_comb begin
      dec_imz                = '0;
      dec_imz[ZIMM_W-1:0]    = io_in_inst[15 +: ZIMM_W];
      dec_imu                = '0;
      dec_imu[31:12]         = io_in_inst[31:12];
   end

   logic [1:0]      ent_sel     [2];
   logic [XLEN-1:0] ent_rsa     [2];
   logic [XLEN-1:0] ent_imz     [2];
   logic [XLEN-1:0] ent_imu     [2];
   logic            ent_illegal [2];
   logic [1:0]      count;
   logic            wr_ptr;
   logic            rd_ptr;
   logic            push;
   logic            pop;

   // Ready comes from registered count only, so upstream never sees a path from io_out_ready.
   assign io_in_ready  = !reset && (count < 2'd2);
   assign io_out_valid = !reset && (count != 2'd0);
   assign push         = io_in_valid && io_in_ready;
   assign pop          = io_out_valid && io_out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            ent_sel[i]     <= 2'd0;
            ent_rsa[i]     <= '0;
            ent_imz[i]     <= '0;
            ent_imu[i]     <= '0;
            ent_illegal[i] <= 1'b0;
         end
      end else if (io_flush) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (push) begin
            ent_sel[wr_ptr]     <= dec_sel;
            ent_rsa[wr_ptr]     <= io_in_rs1_data;
            ent_imz[wr_ptr]     <= dec_imz;
            ent_imu[wr_ptr]     <= dec_imu;
            ent_illegal[wr_ptr] <= dec_illegal;
            wr_ptr              <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Data fields read as zero while reset is held, even before the first reset edge.
   assign io_opa_sel     = reset ? 2'd0 : ent_sel[rd_ptr];
   assign io_opa_rsa     = reset ? '0   : ent_rsa[rd_ptr];
   assign io_opa_imz     = reset ? '0   : ent_imz[rd_ptr];
   assign io_opa_imu     = reset ? '0   : ent_imu[rd_ptr];
   assign io_out_illegal = reset ? 1'b0 : ent_illegal[rd_ptr];

endmodule

`default_nettype wire
